// File: rtl/wb_commit_if.sv
// Writeback-stage commit bundle as produced by the MEM/WB pipeline register.
// The pipeline drives the master side; observers such as the commit monitor use the slave side.
interface wb_commit_if;
   logic        commit;
   logic [63:0] commit_pre_pc;
   logic [31:0] commit_instr;
   logic [63:0] commit_pc;
   logic        reg_wen;
   logic [4:0]  rd;
   logic [63:0] wdata;

   modport master (
      output commit, commit_pre_pc, commit_instr, commit_pc, reg_wen, rd, wdata
   );

   modport slave (
      input  commit, commit_pre_pc, commit_instr, commit_pc, reg_wen, rd, wdata
   );
endinterface

// File: rtl/wb_commit_monitor.sv
// Commit monitor: counts retired instructions and run cycles, checks PC continuity,
// shadows a0 and flags ebreak halts, watchdog timeouts and PC breaks.
//
// state      | meaning
// IDLE       | waiting for the first commit, which must be at RESET_PC
// RUN        | commits flowing, PC chain and watchdog checked
// HALT_GOOD  | ebreak retired with a0 == 0
// HALT_BAD   | ebreak retired with a0 != 0
// TIMEOUT    | no commit for TIMEOUT_CYCLES cycles
// PC_ERR     | commit PC did not match the expected PC
module wb_commit_monitor #(
   parameter logic [63:0] RESET_PC       = 64'h8000_0000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
   parameter logic [31:0] EBREAK_INSTR   = 32'h0010_0073
) (
   input  logic          clk,
   input  logic          rst,
   wb_commit_if.slave    wb_i,
   output logic [2:0]    mon_o_state,
   output logic          mon_o_done,
   output logic [63:0]   mon_o_instret,
   output logic [63:0]   mon_o_cycles,
   output logic [63:0]   mon_o_a0,
   output logic [63:0]   mon_o_err_pc,
   output logic [31:0]   mon_o_idle_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_HALT_GOOD = 3'd2,
      ST_HALT_BAD  = 3'd3,
      ST_TIMEOUT   = 3'd4,
      ST_PC_ERR    = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] err_pc_q, err_pc_d;
   logic [63:0] instret_q;
   logic [63:0] cycles_q;
   logic [63:0] a0_q;
   logic [63:0] exp_pc_q;
   logic [31:0] idle_cnt_q;

   logic        accept;
   logic        a0_wr;
   logic [63:0] a0_eff;
   logic        is_ebreak;
   logic        idle_tc;

   assign accept    = wb_i.commit && ((state_q == ST_IDLE) || (state_q == ST_RUN));
   assign a0_wr     = accept && wb_i.reg_wen && (wb_i.rd == 5'd10);
   // The halting ebreak sees a0 as written by its own commit, if any.
   assign a0_eff    = a0_wr ? wb_i.wdata : a0_q;
   assign is_ebreak = (wb_i.commit_instr == EBREAK_INSTR);
   assign idle_tc   = (idle_cnt_q == (TIMEOUT_CYCLES - 32'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         err_pc_q <= 64'd0;
      end else begin
         state_q  <= state_d;
         err_pc_q <= err_pc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      err_pc_d = err_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (wb_i.commit_pre_pc == RESET_PC) begin
                  state_d = ST_RUN;
               end else begin
                  state_d  = ST_PC_ERR;
                  err_pc_d = RESET_PC;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               // A broken PC chain outranks an ebreak on the same commit.
               if (wb_i.commit_pre_pc != exp_pc_q) begin
                  state_d  = ST_PC_ERR;
                  err_pc_d = exp_pc_q;
               end else if (is_ebreak) begin
                  state_d  = (a0_eff == 64'd0) ? ST_HALT_GOOD : ST_HALT_BAD;
                  err_pc_d = wb_i.commit_pre_pc;
               end
            end else if (idle_tc) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: begin
            state_d  = state_q;
            err_pc_d = err_pc_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instret_q  <= 64'd0;
         cycles_q   <= 64'd0;
         a0_q       <= 64'd0;
         exp_pc_q   <= 64'd0;
         idle_cnt_q <= 32'd0;
      end else begin
         if (accept) begin
            instret_q <= instret_q + 64'd1;
            exp_pc_q  <= wb_i.commit_pc;
         end
         if (a0_wr) begin
            a0_q <= wb_i.wdata;
         end
         if (state_q == ST_RUN) begin
            cycles_q   <= cycles_q + 64'd1;
            idle_cnt_q <= accept ? 32'd0 : (idle_cnt_q + 32'd1);
         end
      end
   end

   assign mon_o_state    = state_q;
   assign mon_o_done     = (state_q != ST_IDLE) && (state_q != ST_RUN);
   assign mon_o_instret  = instret_q;
   assign mon_o_cycles   = cycles_q;
   assign mon_o_a0       = a0_q;
   assign mon_o_err_pc   = err_pc_q;
   assign mon_o_idle_cnt = idle_cnt_q;

endmodule

// File: tb/tb_wb_commit_monitor.sv
// Bench for wb_commit_monitor: table of commit vectors checked through a scoreboard queue,
// plus hand sequences for the watchdog and asynchronous reset.
module tb_wb_commit_monitor;

   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam logic [31:0] EBRK   = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [2:0]  mon_state;
   logic        mon_done;
   logic [63:0] mon_instret;
   logic [63:0] mon_cycles;
   logic [63:0] mon_a0;
   logic [63:0] mon_err_pc;
   logic [31:0] mon_idle_cnt;

   wb_commit_if wb ();

   wb_commit_monitor #(
      .RESET_PC       (RST_PC),
      .TIMEOUT_CYCLES (32'd8),
      .EBREAK_INSTR   (EBRK)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wb_i           (wb.slave),
      .mon_o_state    (mon_state),
      .mon_o_done     (mon_done),
      .mon_o_instret  (mon_instret),
      .mon_o_cycles   (mon_cycles),
      .mon_o_a0       (mon_a0),
      .mon_o_err_pc   (mon_err_pc),
      .mon_o_idle_cnt (mon_idle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_before;
      logic        commit;
      logic [63:0] pre_pc;
      logic [31:0] instr;
      logic [63:0] pc;
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] wdata;
      logic [2:0]  e_state;
      logic [63:0] e_instret;
      logic [63:0] e_a0;
      logic [63:0] e_err;
   } vec_t;

   typedef struct {
      logic [2:0]  state;
      logic [63:0] instret;
      logic [63:0] a0;
      logic [63:0] err;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rb, input logic c, input logic [63:0] pre,
                               input logic [31:0] ins, input logic w, input logic [4:0] rd,
                               input logic [63:0] wd, input logic [2:0] es,
                               input logic [63:0] ei, input logic [63:0] ea, input logic [63:0] ee);
      vec_t v;
      v.rst_before = rb; v.commit = c; v.pre_pc = pre; v.instr = ins; v.pc = pre + 64'd4;
      v.wen = w; v.rd = rd; v.wdata = wd;
      v.e_state = es; v.e_instret = ei; v.e_a0 = ea; v.e_err = ee;
      return v;
   endfunction

   task automatic idle_inputs();
      wb.commit = 1'b0; wb.commit_pre_pc = '0; wb.commit_instr = NOP; wb.commit_pc = '0;
      wb.reg_wen = 1'b0; wb.rd = '0; wb.wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      if (v.rst_before) do_reset();
      @(negedge clk);
      wb.commit = v.commit; wb.commit_pre_pc = v.pre_pc; wb.commit_instr = v.instr;
      wb.commit_pc = v.pc; wb.reg_wen = v.wen; wb.rd = v.rd; wb.wdata = v.wdata;
      e.state = v.e_state; e.instret = v.e_instret; e.a0 = v.e_a0; e.err = v.e_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, " state"},   {61'd0, mon_state}, {61'd0, e.state});
      check({tag, " done"},    {63'd0, mon_done},  {63'd0, (e.state >= 3'd2)});
      check({tag, " instret"}, mon_instret, e.instret);
      check({tag, " a0"},      mon_a0, e.a0);
      check({tag, " err_pc"},  mon_err_pc, e.err);
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      #3;
      check("reset state",   {61'd0, mon_state}, 64'd0);
      check("reset done",    {63'd0, mon_done}, 64'd0);
      check("reset instret", mon_instret, 64'd0);
      check("reset cycles",  mon_cycles, 64'd0);
      check("reset idle",    {32'd0, mon_idle_cnt}, 64'd0);
      check("reset err_pc",  mon_err_pc, 64'd0);
      check("reset a0",      mon_a0, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // straight line to good trap, then an ignored commit
      vt.push_back(mk(1, 1, 64'h8000_0000, NOP,  0, 0,  0, 3'd1, 1, 0, 0));
      vt.push_back(mk(0, 0, 64'h8000_0004, NOP,  0, 0,  0, 3'd1, 1, 0, 0));
      vt.push_back(mk(0, 1, 64'h8000_0004, NOP,  0, 0,  0, 3'd1, 2, 0, 0));
      vt.push_back(mk(0, 1, 64'h8000_0008, EBRK, 0, 0,  0, 3'd2, 3, 0, 64'h8000_0008));
      vt.push_back(mk(0, 1, 64'h8000_000c, NOP,  1, 10, 9, 3'd2, 3, 0, 64'h8000_0008));
      // ebreak that writes a0 itself
      vt.push_back(mk(1, 1, 64'h8000_0000, NOP,  0, 0,  0, 3'd1, 1, 0, 0));
      vt.push_back(mk(0, 1, 64'h8000_0004, EBRK, 1, 10, 5, 3'd3, 2, 5, 64'h8000_0004));
      // same but rd=0: write ignored
      vt.push_back(mk(1, 1, 64'h8000_0000, NOP,  0, 0,  0, 3'd1, 1, 0, 0));
      vt.push_back(mk(0, 1, 64'h8000_0004, EBRK, 1, 0,  5, 3'd2, 2, 0, 64'h8000_0004));
      // a0 set earlier, ebreak uses stored value
      vt.push_back(mk(1, 1, 64'h8000_0000, NOP,  1, 10, 7, 3'd1, 1, 7, 0));
      vt.push_back(mk(0, 1, 64'h8000_0004, NOP,  1, 11, 3, 3'd1, 2, 7, 0));
      vt.push_back(mk(0, 1, 64'h8000_0008, EBRK, 0, 10, 0, 3'd3, 3, 7, 64'h8000_0008));
      // PC break in RUN
      vt.push_back(mk(1, 1, 64'h8000_0000, NOP,  0, 0,  0, 3'd1, 1, 0, 0));
      vt.push_back(mk(0, 1, 64'h8000_0010, NOP,  0, 0,  0, 3'd5, 2, 0, 64'h8000_0004));
      vt.push_back(mk(0, 1, 64'h8000_0004, NOP,  1, 10, 4, 3'd5, 2, 0, 64'h8000_0004));
      // wrong first PC from IDLE
      vt.push_back(mk(1, 1, 64'h8000_1000, NOP,  0, 0,  0, 3'd5, 1, 0, 64'h8000_0000));
      // PC mismatch outranks ebreak
      vt.push_back(mk(1, 1, 64'h8000_0000, NOP,  0, 0,  0, 3'd1, 1, 0, 0));
      vt.push_back(mk(0, 1, 64'h8000_0020, EBRK, 0, 0,  0, 3'd5, 2, 0, 64'h8000_0004));

      foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

      // watchdog: timeout exactly 8 edges after the last commit
      apply(mk(1, 1, RST_PC, NOP, 0, 0, 0, 3'd1, 1, 0, 0), "wd0");
      wb.commit = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         check($sformatf("wd idle%0d", k), {32'd0, mon_idle_cnt}, 64'(k));
         check($sformatf("wd run%0d", k), {61'd0, mon_state}, 64'd1);
      end
      @(posedge clk); #1;
      check("wd timeout", {61'd0, mon_state}, 64'd4);
      check("wd cycles", mon_cycles, 64'd8);
      check("wd instret", mon_instret, 64'd1);

      // watchdog: commit in the last idle cycle rescues the run
      apply(mk(1, 1, RST_PC, NOP, 0, 0, 0, 3'd1, 1, 0, 0), "wr0");
      wb.commit = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      wb.commit = 1'b1; wb.commit_pre_pc = RST_PC + 64'd4; wb.commit_pc = RST_PC + 64'd8;
      @(posedge clk); #1;
      wb.commit = 1'b0;
      check("wr state", {61'd0, mon_state}, 64'd1);
      check("wr idle", {32'd0, mon_idle_cnt}, 64'd0);
      check("wr cycles", mon_cycles, 64'd8);
      begin
         int waited = 0;
         while (!mon_done && waited < 20) begin
            @(posedge clk); #1;
            waited++;
         end
         check("wr timeout state", {61'd0, mon_state}, 64'd4);
         check("wr timeout delay", 64'(waited), 64'd8);
      end

      // asynchronous reset mid-run
      for (int i = 0; i < 7; i++)
         apply(mk(i == 0, 1, RST_PC + 64'(4 * i), NOP, 1, 10, 64'(i + 1), 3'd1,
                  64'(i + 1), 64'(i + 1), 0), $sformatf("ar%0d", i));
      wb.commit = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      check("ar state",   {61'd0, mon_state}, 64'd0);
      check("ar instret", mon_instret, 64'd0);
      check("ar cycles",  mon_cycles, 64'd0);
      check("ar a0",      mon_a0, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      apply(mk(0, 1, RST_PC, NOP, 0, 0, 0, 3'd1, 1, 0, 0), "ar post");

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
